// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt controller: turns divided-clock ticks into one-cycle CPU advance
// pulses, gated by a synchronized run switch, a debounced step button and a halt level.
module cpu_clock_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tickIn,
  input  logic                 runSwitch,
  input  logic                 stepButton,
  input  logic                 halt,
  output logic                 cpuEnable,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycleCount
);

  localparam int unsigned    DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   tick_prev_q;
  logic                   run_meta_q, run_s_q;
  logic                   step_meta_q, step_sync_q;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   stable_q, stable_d, stable_prev_q;
  logic                   cpu_en_q, cpu_en_d;
  logic                   running_q, halted_q;
  logic [CNT_WIDTH-1:0]   cycle_cnt_q;
  logic                   tick_rise;
  logic                   step_press;

  assign tick_rise  = tickIn & ~tick_prev_q;
  assign step_press = stable_q & ~stable_prev_q;

  // Debouncer: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (step_sync_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = step_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Next state and advance pulse; halt wins over every other transition
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt)            state_d = S_HALT;
        else if (run_s_q)    state_d = S_RUN;
        else if (step_press) state_d = S_STEP;
      end
      S_RUN: begin
        if (halt)          state_d = S_HALT;
        else if (!run_s_q) state_d = S_IDLE;
        else               cpu_en_d = tick_rise;
      end
      S_STEP: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (tick_rise) begin
          cpu_en_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      tick_prev_q   <= 1'b0;
      run_meta_q    <= 1'b0;
      run_s_q       <= 1'b0;
      step_meta_q   <= 1'b0;
      step_sync_q   <= 1'b0;
      db_cnt_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cpu_en_q      <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      tick_prev_q   <= tickIn;
      run_meta_q    <= runSwitch;
      run_s_q       <= run_meta_q;
      step_meta_q   <= stepButton;
      step_sync_q   <= step_meta_q;
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cpu_en_q      <= cpu_en_d;
      running_q     <= (state_d == S_RUN);
      halted_q      <= (state_d == S_HALT);
      cycle_cnt_q   <= cycle_cnt_q + CNT_WIDTH'(cpu_en_q);
    end
  end

  assign cpuEnable  = cpu_en_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign cycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl driven by a divide-by-10 tick source.
module tb_cpu_clock_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 8;

  logic          clock;
  logic          reset;
  logic          tickIn;
  logic          runSwitch;
  logic          stepButton;
  logic          halt;
  logic          cpuEnable;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycleCount;

  logic [3:0] div_q = 4'd0;

  int checks   = 0;
  int failures = 0;

  int pulse_cnt = 0;
  int width_err = 0;
  int align_err = 0;
  int p0;
  logic en_prev = 1'b0;
  logic t1 = 1'b0;
  logic t2 = 1'b0;

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tickIn    (tickIn),
    .runSwitch (runSwitch),
    .stepButton(stepButton),
    .halt      (halt),
    .cpuEnable (cpuEnable),
    .running   (running),
    .halted    (halted),
    .cycleCount(cycleCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divide-by-10 tick source: high for 5 cycles, rising when the counter wraps to 0
  always @(posedge clock) div_q <= (div_q == 4'd9) ? 4'd0 : div_q + 4'd1;
  assign tickIn = (div_q < 4'd5);

  // Pulse monitor: counts pulses, flags wide pulses and pulses not one cycle after a tick rise
  always @(negedge clock) begin
    if (cpuEnable) begin
      pulse_cnt = pulse_cnt + 1;
      if (en_prev) width_err = width_err + 1;
      if (!(t1 && !t2)) align_err = align_err + 1;
    end
    en_prev = cpuEnable;
    t2      = t1;
    t1      = tickIn;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_div(input logic [3:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (div_q != v && n < 20);
    if (div_q != v) check_eq("wait_div_timeout", 32'(div_q), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    runSwitch  = 1'b1;
    stepButton = 1'b0;
    halt       = 1'b0;

    // 1. reset and free-run
    cycles(3);
    check_eq("rst_cpuEnable", 32'(cpuEnable), 0);
    check_eq("rst_running",   32'(running), 0);
    check_eq("rst_halted",    32'(halted), 0);
    check_eq("rst_count",     32'(cycleCount), 0);
    wait_div(4'd2);
    reset = 1'b1;
    p0 = pulse_cnt;
    cycles(3);
    check_eq("run_after_release", 32'(running), 1);
    repeat (5) begin
      wait_div(4'd0);
      wait_div(4'd2);
    end
    check_eq("run_count5",  32'(cycleCount), 5);
    check_eq("run_pulses5", 32'(pulse_cnt - p0), 5);

    // 2. single step
    runSwitch = 1'b0;
    wait_div(4'd9);
    check_eq("idle_running", 32'(running), 0);
    p0 = pulse_cnt;
    stepButton = 1'b1;
    cycles(20);
    check_eq("step_one_pulse", 32'(pulse_cnt - p0), 1);
    stepButton = 1'b0;
    cycles(100);
    check_eq("step_no_more",  32'(pulse_cnt - p0), 1);
    check_eq("step_count",    32'(cycleCount), 6);
    check_eq("step_idle_run", 32'(running), 0);

    // 3. debounce
    p0 = pulse_cnt;
    repeat (5) begin
      stepButton = 1'b1;
      cycles(2);
      stepButton = 1'b0;
      cycles(2);
    end
    cycles(40);
    check_eq("bounce_no_pulse", 32'(pulse_cnt - p0), 0);
    check_eq("bounce_count",    32'(cycleCount), 6);
    stepButton = 1'b1;
    cycles(2);
    stepButton = 1'b0;
    cycles(3);
    stepButton = 1'b1;
    cycles(12);
    stepButton = 1'b0;
    cycles(40);
    check_eq("glitch_press_one", 32'(pulse_cnt - p0), 1);
    check_eq("glitch_count",     32'(cycleCount), 7);

    // 4. halt coincident with a tick rise
    wait_div(4'd2);
    runSwitch = 1'b1;
    wait_div(4'd2);
    wait_div(4'd0);
    halt = 1'b1;
    @(negedge clock);
    check_eq("halt_tick_no_pulse", 32'(cpuEnable), 0);
    check_eq("halt_halted",        32'(halted), 1);
    check_eq("halt_running",       32'(running), 0);
    check_eq("halt_count",         32'(cycleCount), 8);
    p0 = pulse_cnt;
    halt = 1'b0;
    runSwitch = 1'b0;
    cycles(15);
    runSwitch = 1'b1;
    cycles(15);
    stepButton = 1'b1;
    cycles(15);
    stepButton = 1'b0;
    cycles(30);
    check_eq("halt_absorb_pulses", 32'(pulse_cnt - p0), 0);
    check_eq("halt_absorb_count",  32'(cycleCount), 8);
    check_eq("halt_sticky",        32'(halted), 1);
    reset = 1'b0;
    cycles(2);
    check_eq("halt_rst_halted", 32'(halted), 0);
    check_eq("halt_rst_count",  32'(cycleCount), 0);

    // 5. counter wrap and switch-off exactly at a tick
    wait_div(4'd2);
    reset = 1'b1;
    repeat (255) begin
      wait_div(4'd0);
      wait_div(4'd2);
    end
    check_eq("preload_255", 32'(cycleCount), 255);
    wait_div(4'd0);
    wait_div(4'd2);
    check_eq("wrap_to_0", 32'(cycleCount), 0);
    wait_div(4'd8);
    runSwitch = 1'b0;
    wait_div(4'd1);
    check_eq("switchoff_no_pulse", 32'(cpuEnable), 0);
    check_eq("switchoff_idle",     32'(running), 0);
    p0 = pulse_cnt;
    cycles(30);
    check_eq("switchoff_pulses", 32'(pulse_cnt - p0), 0);
    check_eq("switchoff_count",  32'(cycleCount), 0);

    // 6. reset while a step is pending
    wait_div(4'd2);
    p0 = pulse_cnt;
    stepButton = 1'b1;
    wait_div(4'd9);
    reset = 1'b0;
    stepButton = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(40);
    check_eq("rststep_pulses",  32'(pulse_cnt - p0), 0);
    check_eq("rststep_count",   32'(cycleCount), 0);
    check_eq("rststep_running", 32'(running), 0);
    check_eq("rststep_halted",  32'(halted), 0);

    check_eq("pulse_width_errors", 32'(width_err), 0);
    check_eq("pulse_align_errors", 32'(align_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
